// File: rtl/rd_load_unit.sv
// Load unit: computes data1 + ext_imm, issues one word read on the data bus and returns the
// extracted/extended LB/LH/LW/LBU/LHU result. Optional bus timeout: define LOAD_TIMEOUT_EN.
module rd_load_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] data1,
  input  logic [31:0] ext_imm,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        misalign,
  output logic        timeout,
  output logic        busy
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // S_MISAL is a one-cycle hold that makes a rejected access report at the
  // same latency as a zero-wait bus read.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_MISAL, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_sum;
  logic        bad_access;
  logic [1:0]  lane_q;
  logic [2:0]  f3_q;
  logic [31:0] mem_addr_q;
  logic [31:0] ld_data_q;
  logic        mis_q;
  logic        tmo_q;
  logic        expire;

  assign addr_sum = data1 + ext_imm;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first, otherwise a latch is inferred.
    bad_access = 1'b0;
    case (funct3)
      F3_LB, F3_LBU: bad_access = 1'b0;
      F3_LH, F3_LHU: bad_access = addr_sum[0];
      F3_LW:         bad_access = |addr_sum[1:0];
      default:       bad_access = 1'b1;
    endcase
  end

`ifdef LOAD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == S_REQ) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign expire = (state == S_REQ) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expire             = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = bad_access ? S_MISAL : S_REQ;
      S_REQ:   if (mem_ack || expire) state_nxt = S_DONE;
      S_MISAL: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lane,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   extract = {{24{b[7]}}, b};
      F3_LBU:  extract = {24'h0, b};
      F3_LH:   extract = {{16{h[15]}}, h};
      F3_LHU:  extract = {16'h0, h};
      default: extract = word;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q <= '0;
      lane_q     <= '0;
      f3_q       <= '0;
      ld_data_q  <= '0;
      mis_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mem_addr_q <= {addr_sum[31:2], 2'b00};
            lane_q     <= addr_sum[1:0];
            f3_q       <= funct3;
          end
        end
        S_REQ: begin
          // An ack arriving in the expiry cycle takes priority over the abort.
          if (mem_ack) begin
            ld_data_q <= extract(f3_q, lane_q, mem_rdata);
            mis_q     <= 1'b0;
            tmo_q     <= 1'b0;
          end else if (expire) begin
            ld_data_q <= '0;
            mis_q     <= 1'b0;
            tmo_q     <= 1'b1;
          end
        end
        S_MISAL: begin
          ld_data_q <= '0;
          mis_q     <= 1'b1;
          tmo_q     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_req  = (state == S_REQ);
  assign mem_addr = mem_addr_q;
  assign busy     = (state != S_IDLE);
  assign ld_valid = (state == S_DONE);
  assign ld_data  = ld_data_q;
  assign misalign = ld_valid & mis_q;
`ifdef LOAD_TIMEOUT_EN
  assign timeout  = ld_valid & tmo_q;
`else
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_rd_load_unit.sv
// Directed self-checking bench for rd_load_unit: vector table plus hand-written corner sequences.
module tb_rd_load_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] data1;
  logic [31:0] ext_imm;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        misalign;
  logic        timeout;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rd_load_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .data1(data1),
    .ext_imm(ext_imm), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ld_data(ld_data), .ld_valid(ld_valid), .misalign(misalign),
    .timeout(timeout), .busy(busy)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] d1;
    logic [31:0] imm;
    int          wait_cyc;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_vec(input int idx, input vec_t v);
    @(negedge clk);
    start = 1'b1; funct3 = v.f3; data1 = v.d1; ext_imm = v.imm;
    @(negedge clk);
    start = 1'b0;
    if (v.exp_mis) begin
      check($sformatf("v%0d mis_req_n1", idx), mem_req, 1'b0);
      check($sformatf("v%0d mis_valid_n1", idx), ld_valid, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d mis_req_n2", idx), mem_req, 1'b0);
      check($sformatf("v%0d mis_valid", idx), ld_valid, 1'b1);
      check($sformatf("v%0d mis_flag", idx), misalign, 1'b1);
      check($sformatf("v%0d mis_data", idx), ld_data, 32'h0);
    end else begin
      for (int c = 0; c < v.wait_cyc; c++) begin
        check($sformatf("v%0d req_wait", idx), mem_req, 1'b1);
        check($sformatf("v%0d valid_wait", idx), ld_valid, 1'b0);
        @(negedge clk);
      end
      check($sformatf("v%0d req", idx), mem_req, 1'b1);
      check($sformatf("v%0d addr", idx), mem_addr, v.exp_addr);
      mem_ack = 1'b1; mem_rdata = v.rdata;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'hA5A5_A5A5;
      check($sformatf("v%0d valid", idx), ld_valid, 1'b1);
      check($sformatf("v%0d data", idx), ld_data, v.exp_data);
      check($sformatf("v%0d misflag", idx), misalign, 1'b0);
      check($sformatf("v%0d tmo", idx), timeout, 1'b0);
      check($sformatf("v%0d req_drop", idx), mem_req, 1'b0);
    end
    @(negedge clk);
    check($sformatf("v%0d pulse_end", idx), ld_valid, 1'b0);
    check($sformatf("v%0d idle", idx), busy, 1'b0);
  endtask

  initial begin
    int cnt;
    vecs[0]  = '{3'b010, 32'h0000_0100, 32'h0000_0004, 2, 32'hDEAD_BEEF, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{3'b000, 32'h0000_0200, 32'h0000_0003, 0, 32'h80FF_0000, 32'h0000_0200, 32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{3'b100, 32'h0000_0200, 32'h0000_0003, 0, 32'h80FF_0000, 32'h0000_0200, 32'h0000_0080, 1'b0};
    vecs[3]  = '{3'b001, 32'h0000_0101, 32'h0000_0000, 0, 32'h0,         32'h0,         32'h0,         1'b1};
    vecs[4]  = '{3'b010, 32'hFFFF_FFFC, 32'h0000_0008, 1, 32'h1234_5678, 32'h0000_0004, 32'h1234_5678, 1'b0};
    vecs[5]  = '{3'b001, 32'h0000_0300, 32'h0000_0002, 0, 32'h8001_7FFF, 32'h0000_0300, 32'hFFFF_8001, 1'b0};
    vecs[6]  = '{3'b101, 32'h0000_0400, 32'h0000_0000, 3, 32'h1234_F00D, 32'h0000_0400, 32'h0000_F00D, 1'b0};
    vecs[7]  = '{3'b000, 32'h0000_0500, 32'h0000_0001, 0, 32'h0000_7F00, 32'h0000_0500, 32'h0000_007F, 1'b0};
    vecs[8]  = '{3'b010, 32'h0000_0600, 32'h0000_0002, 0, 32'h0,         32'h0,         32'h0,         1'b1};
    vecs[9]  = '{3'b011, 32'h0000_0700, 32'h0000_0000, 0, 32'h0,         32'h0,         32'h0,         1'b1};
    vecs[10] = '{3'b100, 32'h0000_1000, 32'hFFFF_FFF0, 1, 32'hAABB_CCDD, 32'h0000_0FF0, 32'h0000_00DD, 1'b0};
    vecs[11] = '{3'b101, 32'h0000_0100, 32'h0000_0001, 0, 32'h0,         32'h0,         32'h0,         1'b1};

    rst_n = 1'b0; start = 1'b0; funct3 = 3'b0; data1 = '0; ext_imm = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #12;
    check("rst mem_req", mem_req, 1'b0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst ld_data", ld_data, 32'h0);
    check("rst ld_valid", ld_valid, 1'b0);
    check("rst misalign", misalign, 1'b0);
    check("rst timeout", timeout, 1'b0);
    check("rst busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) do_vec(i, vecs[i]);

    // start while busy, and start coincident with ld_valid, are both dropped
    @(negedge clk);
    start = 1'b1; funct3 = 3'b010; data1 = 32'h0000_0800; ext_imm = '0;
    @(negedge clk);
    data1 = 32'h0000_0900;
    check("busy_ign addr", mem_addr, 32'h0000_0800);
    @(negedge clk);
    start = 1'b0;
    check("busy_ign req", mem_req, 1'b1);
    check("busy_ign addr2", mem_addr, 32'h0000_0800);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_ack = 1'b0;
    check("busy_ign valid", ld_valid, 1'b1);
    check("busy_ign data", ld_data, 32'hCAFE_F00D);
    start = 1'b1; data1 = 32'h0000_0A00;
    @(negedge clk);
    check("done_start busy", busy, 1'b0);
    check("done_start req", mem_req, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("late_start req", mem_req, 1'b1);
    check("late_start addr", mem_addr, 32'h0000_0A00);
    mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_start data", ld_data, 32'h1122_3344);
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray_ack valid", ld_valid, 1'b0);
    check("stray_ack busy", busy, 1'b0);

    // asynchronous reset in the middle of a request
    start = 1'b1; funct3 = 3'b010; data1 = 32'h0000_0C00;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst req", mem_req, 1'b0);
    check("async_rst busy", busy, 1'b0);
    check("async_rst addr", mem_addr, 32'h0);
    check("async_rst data", ld_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack valid", ld_valid, 1'b0);
    @(negedge clk);
    check("late_ack valid2", ld_valid, 1'b0);
    check("late_ack data", ld_data, 32'h0);

    // bus never answers
    start = 1'b1; funct3 = 3'b010; data1 = 32'h0000_0B00;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
`ifdef LOAD_TIMEOUT_EN
    while (mem_req && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("tmo req_cycles", cnt, 16);
    check("tmo valid", ld_valid, 1'b1);
    check("tmo flag", timeout, 1'b1);
    check("tmo data", ld_data, 32'h0);
    check("tmo misalign", misalign, 1'b0);
`else
    while (mem_req && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("no_tmo req_cycles", cnt, 40);
    check("no_tmo req_held", mem_req, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    mem_ack = 1'b0;
    check("no_tmo valid", ld_valid, 1'b1);
    check("no_tmo flag", timeout, 1'b0);
    check("no_tmo data", ld_data, 32'h0BAD_F00D);
`endif
    @(negedge clk);
    check("final idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
